// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits, LSB first, optional parity, one stop bit.
// The line output is registered; in_ready and busy are decoded from the state.
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [15:0] LAST_TICK = 16'(CLKS_PER_BIT - 1);
    localparam logic        ODD       = (PARITY_ODD != 0);
    localparam logic        USE_PAR   = (PARITY_EN != 0);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        par_q, par_d;
    logic        tx_q, tx_d;
    logic        done_q, done_d;
    logic        bit_end;

    assign bit_end  = (timer_q == LAST_TICK);
    assign in_ready = rst && (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign tx       = tx_q;
    assign done     = done_q;

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        state_d = state_q;
        timer_d = bit_end ? 16'd0 : timer_q + 16'd1;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = 16'd0;
                if (in_valid) begin
                    state_d = START;
                    shreg_d = in_data;
                    par_d   = (^in_data) ^ ODD;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = {1'b0, shreg_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = USE_PAR ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is chosen from the state being entered so tx is a pure flop.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            timer_q <= 16'd0;
            idx_q   <= 3'd0;
            shreg_q <= 8'd0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: plain, even-parity and odd-parity instances
// checked cycle by cycle against frames built from the byte under test.
module tb_uart_tx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] in_valid;
    logic [7:0] in_data [3];
    logic [2:0] in_ready;
    logic [2:0] tx;
    logic [2:0] busy;
    logic [2:0] done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_data(in_data[0]),
        .in_ready(in_ready[0]), .tx(tx[0]), .busy(busy[0]), .done(done[0])
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_data(in_data[1]),
        .in_ready(in_ready[1]), .tx(tx[1]), .busy(busy[1]), .done(done[1])
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_data(in_data[2]),
        .in_ready(in_ready[2]), .tx(tx[2]), .busy(busy[2]), .done(done[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer a byte at the current negedge; returns at the first start-bit cycle.
    task automatic start_frame(input int d, input logic [7:0] data, input bit hold);
        #1;
        check($sformatf("dut%0d ready_before_send", d), {31'd0, in_ready[d]}, 32'd1);
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        @(negedge clk);
        if (!hold) in_valid[d] = 1'b0;
    endtask

    // Checks every cycle of a frame; returns at the done cycle.
    task automatic check_frame(input int d, input logic [7:0] data, input int nbits,
                               input logic par, input int inj_at);
        int   cyc = 0;
        logic exp;
        for (int b = 0; b < nbits; b++) begin
            int tx_err = 0;
            int ctl_err = 0;
            if (b == 0)                     exp = 1'b0;
            else if (b <= 8)                exp = data[b-1];
            else if (nbits == 11 && b == 9) exp = par;
            else                            exp = 1'b1;
            for (int c = 0; c < CPB; c++) begin
                if (inj_at >= 0 && cyc == inj_at) begin
                    in_valid[d] = 1'b1;
                    in_data[d]  = 8'h3C;
                end else if (inj_at >= 0 && cyc == inj_at + 1) begin
                    in_valid[d] = 1'b0;
                end
                if (tx[d] !== exp) tx_err++;
                if (busy[d] !== 1'b1 || done[d] !== 1'b0 || in_ready[d] !== 1'b0) ctl_err++;
                @(negedge clk);
                cyc++;
            end
            check($sformatf("dut%0d data=%02h bit%0d tx_cycles_wrong", d, data, b), tx_err, 0);
            check($sformatf("dut%0d data=%02h bit%0d ctl_cycles_wrong", d, data, b), ctl_err, 0);
        end
        check($sformatf("dut%0d data=%02h done_pulse", d, data), {31'd0, done[d]}, 32'd1);
        check($sformatf("dut%0d data=%02h tx_idle_at_done", d, data), {31'd0, tx[d]}, 32'd1);
        check($sformatf("dut%0d data=%02h busy_at_done", d, data), {31'd0, busy[d]}, 32'd0);
        check($sformatf("dut%0d data=%02h ready_at_done", d, data), {31'd0, in_ready[d]}, 32'd1);
    endtask

    initial begin
        int idle_err;

        rst      = 1'b0;
        in_valid = 3'b000;
        for (int i = 0; i < 3; i++) in_data[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("reset tx", {29'd0, tx}, 32'h7);
        check("reset busy", {29'd0, busy}, 32'h0);
        check("reset done", {29'd0, done}, 32'h0);
        check("reset ready_low", {29'd0, in_ready}, 32'h0);
        rst = 1'b1;
        #1;
        check("ready_after_release", {29'd0, in_ready}, 32'h7);
        @(negedge clk);

        // Plain frame of A5: 160 cycles, done one cycle after the stop bit.
        start_frame(0, 8'hA5, 1'b0);
        check_frame(0, 8'hA5, 10, 1'b0, -1);
        @(negedge clk);
        check("a5 done_one_cycle", {31'd0, done[0]}, 32'd0);

        // Parity frames of A5 (four ones): even -> 0, odd -> 1, 176 cycles.
        start_frame(1, 8'hA5, 1'b0);
        check_frame(1, 8'hA5, 11, 1'b0, -1);
        @(negedge clk);
        check("even_par done_one_cycle", {31'd0, done[1]}, 32'd0);
        start_frame(2, 8'hA5, 1'b0);
        check_frame(2, 8'hA5, 11, 1'b1, -1);
        @(negedge clk);
        check("odd_par done_one_cycle", {31'd0, done[2]}, 32'd0);

        // Back-to-back: in_valid held, data switched to FF mid-frame.
        start_frame(0, 8'h00, 1'b1);
        in_data[0] = 8'hFF;
        check_frame(0, 8'h00, 10, 1'b0, -1);
        @(negedge clk);
        in_valid[0] = 1'b0;
        check_frame(0, 8'hFF, 10, 1'b0, -1);
        @(negedge clk);
        check("b2b done_one_cycle", {31'd0, done[0]}, 32'd0);

        // Byte offered during DATA bit 3 must be ignored, no trailing frame.
        start_frame(0, 8'h96, 1'b0);
        check_frame(0, 8'h96, 10, 1'b0, CPB + 3 * CPB + 2);
        idle_err = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) idle_err++;
        end
        check("no_extra_frame idle_cycles_wrong", idle_err, 0);

        // Reset during DATA bit 3 aborts the frame without a done pulse.
        start_frame(0, 8'hA5, 1'b0);
        repeat (CPB + 3 * CPB + 5) @(negedge clk);
        check("pre_abort busy", {31'd0, busy[0]}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("abort tx", {31'd0, tx[0]}, 32'd1);
        check("abort busy", {31'd0, busy[0]}, 32'd0);
        check("abort done", {31'd0, done[0]}, 32'd0);
        check("abort ready_low", {31'd0, in_ready[0]}, 32'd0);
        @(negedge clk);
        check("abort done_still_low", {31'd0, done[0]}, 32'd0);
        rst = 1'b1;
        start_frame(0, 8'h5A, 1'b0);
        check_frame(0, 8'h5A, 10, 1'b0, -1);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit, legal range 2..65535.
REQ-002 SHALL have parameter PARITY_EN, default 0: 1 inserts a parity bit after data bit 7.
REQ-003 SHALL have parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
REQ-004 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  byte offered on in_data.
REQ-007 SHALL have port in_data  input  8  byte to transmit.
REQ-008 SHALL have port in_ready  output  1  block can accept a byte this cycle.
REQ-009 SHALL have port tx  output  1  serial line; idle high; drives uart_rx rx.
REQ-010 SHALL have port busy  output  1  frame in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse at end of frame.

Function
REQ-012 SHALL use states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL drive in_ready=1 only in IDLE with rst high, derived combinationally from state.
REQ-014 SHALL accept a byte on a rising edge where in_valid=1 and in_ready=1, latch in_data into a shift register, and enter START.
REQ-015 SHALL ignore in_valid and in_data while in_ready=0; in_data changes mid-frame do not alter the frame.
REQ-016 SHALL hold every bit on tx for exactly CLKS_PER_BIT cycles, using a bit-timer counting 0..CLKS_PER_BIT-1 that restarts at each bit boundary.
REQ-017 SHALL drive tx=0 in START, the first tx=0 cycle being the cycle after the accepting edge.
REQ-018 SHALL transmit data LSB first in DATA; a 3-bit index counts 0..7, and DATA exits after index 7 finishes.
REQ-019 SHALL, when PARITY_EN=1, go DATA->PARITY and drive tx = XOR of the 8 latched bits XOR PARITY_ODD; when PARITY_EN=0, go DATA->STOP directly.
REQ-020 SHALL drive tx=1 in STOP for CLKS_PER_BIT cycles, then return to IDLE.
REQ-021 SHALL give a frame length, first start cycle to last stop cycle, of 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT when PARITY_EN=1.
REQ-022 SHALL assert busy=1 in every non-IDLE state, else 0.
REQ-023 SHALL pulse done=1 (registered) for exactly one cycle: the first IDLE cycle after STOP, the same cycle in_ready returns to 1.
REQ-024 SHALL support back-to-back frames: a byte held on in_valid is accepted in the done cycle, giving exactly one idle tx=1 cycle between the stop bit and the next start bit.
REQ-025 SHALL drive tx=1 in IDLE.
REQ-026 SHALL register tx (no combinational glitches on the line).

Reset
REQ-027 SHALL, on any rising edge with rst=0, including mid-frame, set state=IDLE, tx=1, busy=0, done=0, bit-timer=0, bit index=0, shift register=0.
REQ-028 SHALL hold in_ready=0 while rst=0, and SHALL NOT emit a done pulse for a frame aborted by reset.
REQ-029 SHALL, after rst rises, give in_ready=1 on the first cycle; a byte offered then is accepted normally.

Verification
REQ-030 SHALL be verified by: default params, send 8'hA5 -> tx is 0 | 1,0,1,0,0,1,0,1 | 1, each bit 16 cycles, 160 cycles total; busy high throughout; done 1 cycle after the stop bit.
REQ-031 SHALL be verified by: tx looped into uart_rx (100 MHz, 16 clk/bit), send 8'hA5 -> uart_rx done pulses with data=8'hA5.
REQ-032 SHALL be verified by: PARITY_EN=1, send 8'hA5 -> parity bit 0 with PARITY_ODD=0, 1 with PARITY_ODD=1; frame 176 cycles.
REQ-033 SHALL be verified by: in_valid held with 8'h00 then 8'hFF -> two frames separated by exactly one idle cycle; second frame data bits all 1.
REQ-034 SHALL be verified by: in_valid pulsed with 8'h3C during DATA -> ignored; line and frame unchanged; no extra frame afterwards.
REQ-035 SHALL be verified by: rst driven low during DATA bit 3 -> next edge gives tx=1, busy=0, no done pulse; after release, 8'h5A transmits correctly.
